// File: rtl/sevenseg_capture.sv
// Rebuilds the 8 digit patterns shown on a scanned, active-low 7-segment bus.
// Optional SEVENSEG_HEX_DECODE_EN adds per-digit hex glyph decode outputs hex_out/hex_ok.
module sevenseg_capture #(
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an_n,
    input  logic [6:0]  segs_n,
    input  logic        dp_n,
    output logic [55:0] seg_out,
    output logic [7:0]  dp_out,
    output logic [7:0]  digit_upd,
    output logic        frame_done,
    output logic        an_err,
    output logic        stale
`ifdef SEVENSEG_HEX_DECODE_EN
    ,
    output logic [31:0] hex_out,
    output logic [7:0]  hex_ok
`endif
);

    localparam int unsigned NDIG  = 8;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned BUS_W = 16;
    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]     SETTLE_C = CNT_W'(SETTLE);
    localparam logic [TIMEOUT_W-1:0] IDLE_MAX = '1;

    logic [BUS_W-1:0]       sync1_q, bus_q, prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   armed_q, armed_d;
    logic [NDIG*SEG_W-1:0]  seg_q, seg_d;
    logic [NDIG-1:0]        dp_q, dp_d;
    logic [NDIG-1:0]        upd_q, upd_d;
    logic [NDIG-1:0]        seen_q, seen_d;
    logic                   frame_q, frame_d;
    logic                   err_q, err_d;
    logic                   stale_q, stale_d;
    logic [TIMEOUT_W-1:0]   idle_q, idle_d;

    logic [7:0]             an_low;
    logic [6:0]             seg_on;
    logic                   changed, settle, onehot;
    logic [NDIG-1:0]        seen_new;

`ifdef SEVENSEG_HEX_DECODE_EN
    logic [4*NDIG-1:0]      hex_q, hex_d;
    logic [NDIG-1:0]        ok_q, ok_d;

    // Returns {valid, nibble} for an active-high gfedcba glyph.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction
`endif

    // Stability tracking, anode decode and capture next-state.
    always_comb begin
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        upd_d    = '0;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
        idle_d   = (idle_q == IDLE_MAX) ? idle_q : idle_q + TIMEOUT_W'(1);
        seen_new = seen_q;
`ifdef SEVENSEG_HEX_DECODE_EN
        hex_d    = hex_q;
        ok_d     = ok_q;
`endif

        an_low  = ~bus_q[15:8];
        seg_on  = ~bus_q[7:1];
        changed = (bus_q != prev_q);
        onehot  = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);

        if (changed) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (cnt_q != SETTLE_C) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // One settle event per stable bus value.
        settle = !changed && armed_q && (cnt_d == SETTLE_C);

        if (settle) begin
            armed_d = 1'b0;
            if (onehot) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (an_low[i]) begin
                        seg_d[SEG_W*i +: SEG_W] = seg_on;
                        dp_d[i]                 = ~bus_q[0];
                        upd_d[i]                = 1'b1;
`ifdef SEVENSEG_HEX_DECODE_EN
                        hex_d[4*i +: 4]         = hex_decode(seg_on)[3:0];
                        ok_d[i]                 = hex_decode(seg_on)[4];
`endif
                    end
                end
                idle_d   = '0;
                seen_new = seen_q | upd_d;
                if (seen_new == '1) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d = seen_new;
                end
            end else if (an_low != 8'd0) begin
                err_d = 1'b1;
            end
        end

        stale_d = (idle_d == IDLE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            bus_q   <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            seg_q   <= '0;
            dp_q    <= '0;
            upd_q   <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
            idle_q  <= '0;
`ifdef SEVENSEG_HEX_DECODE_EN
            hex_q   <= '0;
            ok_q    <= '0;
`endif
        end else begin
            sync1_q <= {an_n, segs_n, dp_n};
            bus_q   <= sync1_q;
            prev_q  <= bus_q;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            upd_q   <= upd_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            idle_q  <= idle_d;
`ifdef SEVENSEG_HEX_DECODE_EN
            hex_q   <= hex_d;
            ok_q    <= ok_d;
`endif
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_upd  = upd_q;
    assign frame_done = frame_q;
    assign an_err     = err_q;
    assign stale      = stale_q;
`ifdef SEVENSEG_HEX_DECODE_EN
    assign hex_out    = hex_q;
    assign hex_ok     = ok_q;
`endif

endmodule
